// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a sync_fifo read port and serialises each
// one as an async UART frame (start, DATA_W bits LSB first, optional parity,
// 1 or 2 stop bits) on txd.
module fifo_uart_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              txd,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic              HAS_PAR   = (PARITY != 0);
  localparam logic              ODD_PAR   = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    CAP   = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    PAR   = 3'd5,
    STOP  = 3'd6
  } state_t;

  state_t              state, state_d;
  logic [BAUD_W-1:0]   baud_cnt, baud_cnt_d;
  logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
  logic [DATA_W-1:0]   shreg, shreg_d;
  logic                par_bit, par_bit_d;
  logic                txd_d;
  logic                fifo_rd_en_d;
  logic                busy_d;
  logic                frame_done_d;
  logic                baud_end_c;

  // End of the current bit period.
  assign baud_end_c = (baud_cnt == BAUD_LAST);

  // State register and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      txd        <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      baud_cnt   <= baud_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      par_bit    <= par_bit_d;
      txd        <= txd_d;
      fifo_rd_en <= fifo_rd_en_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
    end
  end

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d      = state;
    baud_cnt_d   = baud_cnt;
    bit_cnt_d    = bit_cnt;
    shreg_d      = shreg;
    par_bit_d    = par_bit;
    txd_d        = txd;
    fifo_rd_en_d = 1'b0;
    frame_done_d = 1'b0;

    case (state)
      IDLE: begin
        txd_d = 1'b1;
        if (enable && !fifo_empty) begin
          state_d      = REQ;
          fifo_rd_en_d = 1'b1;
        end
      end

      // FIFO pops on the edge leaving REQ; its data is valid during CAP.
      REQ: begin
        state_d = CAP;
      end

      CAP: begin
        shreg_d   = fifo_dout;
        par_bit_d = (^fifo_dout) ^ ODD_PAR;
        state_d   = START;
        txd_d     = 1'b0;
      end

      START: begin
        if (baud_end_c) begin
          state_d = DATA;
          txd_d   = shreg[0];
        end
      end

      // shreg[0] is always the bit currently on the line.
      DATA: begin
        if (baud_end_c) begin
          if (bit_cnt == BIT_LAST) begin
            if (HAS_PAR) begin
              state_d = PAR;
              txd_d   = par_bit;
            end else begin
              state_d = STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shreg_d   = shreg >> 1;
            txd_d     = shreg_d[0];
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
      end

      PAR: begin
        if (baud_end_c) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end

      // bit_cnt counts stop bits here.
      STOP: begin
        txd_d = 1'b1;
        if (baud_end_c) begin
          if (bit_cnt == STOP_LAST) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Both counters restart on every state change.
    if (state_d != state) begin
      baud_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (state inside {START, DATA, PAR, STOP}) begin
      baud_cnt_d = baud_end_c ? '0 : baud_cnt + BAUD_W'(1);
    end

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed self-checking bench for fifo_uart_tx with a behavioural FIFO model
// and a UART line decoder on the main instance.
module tb_fifo_uart_tx;

  logic clk = 1'b0;
  logic rstn = 1'b0;

  // Main instance: CLKS_PER_BIT=4, no parity, 1 stop bit.
  logic       enable0 = 1'b0;
  logic       fifo_empty0;
  logic [7:0] dout0 = 8'h00;
  logic       rd_en0, txd0, busy0, frame_done0;

  // Parity instances share stimulus: odd/2 stop and even/2 stop.
  logic       p_en = 1'b0;
  logic       p_empty = 1'b1;
  logic [7:0] p_dout = 8'h00;
  logic       rd1, txd1, busy1, fd1;
  logic       rd2, txd2, busy2, fd2;

  always #5 clk = ~clk;

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rstn(rstn), .enable(enable0), .fifo_empty(fifo_empty0),
    .fifo_dout(dout0), .fifo_rd_en(rd_en0), .txd(txd0), .busy(busy0),
    .frame_done(frame_done0)
  );

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rstn(rstn), .enable(p_en), .fifo_empty(p_empty),
    .fifo_dout(p_dout), .fifo_rd_en(rd1), .txd(txd1), .busy(busy1),
    .frame_done(fd1)
  );

  fifo_uart_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rstn(rstn), .enable(p_en), .fifo_empty(p_empty),
    .fifo_dout(p_dout), .fifo_rd_en(rd2), .txd(txd2), .busy(busy2),
    .frame_done(fd2)
  );

  // Behavioural FIFO, depth 16, cleared by rstn.
  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_empty_err = 0;
  assign fifo_empty0 = (wr_ptr == rd_ptr);

  // FIFO pop side; also flags any read attempted while empty.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= wr_ptr;
    end else if (rd_en0) begin
      if (fifo_empty0) rd_empty_err <= rd_empty_err + 1;
      else begin
        dout0  <= mem[4'(rd_ptr % 16)];
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_cnt = 0;
  int busy_cnt = 0;
  int done_cyc = 0;
  int have_done = 0;
  int fall_cyc = 0;
  int flen = 0;

  // Activity counters and frame timing.
  always @(negedge clk) begin
    if (rd_en0) rd_cnt <= rd_cnt + 1;
    if (busy0) busy_cnt <= busy_cnt + 1;
    if (frame_done0) begin
      done_cyc  <= cyc;
      have_done <= 1;
      flen      <= cyc - fall_cyc;
    end
  end

  // UART decoder: samples mid-bit, indices counted in clocks from the start bit.
  logic       mon_active = 1'b0;
  int         mon_idx = 0;
  logic [7:0] mon_byte = 8'h00;
  int         stop_err = 0;
  logic [7:0] decoded [$];
  int         gaps [$];

  always @(negedge clk) begin
    if (!rstn) begin
      mon_active <= 1'b0;
    end else if (!mon_active) begin
      if (!txd0) begin
        mon_active <= 1'b1;
        mon_idx    <= 1;
        fall_cyc   <= cyc;
        if (have_done != 0) gaps.push_back(cyc - done_cyc);
      end
    end else begin
      mon_idx <= mon_idx + 1;
      if ((mon_idx % 4 == 2) && mon_idx >= 6 && mon_idx <= 34)
        mon_byte[3'((mon_idx - 6) / 4)] <= txd0;
      if (mon_idx == 38) begin
        decoded.push_back(mon_byte);
        if (!txd0) stop_err <= stop_err + 1;
      end
      if (mon_idx == 39) mon_active <= 1'b0;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    mem[4'(wr_ptr % 16)] = d;
    wr_ptr = wr_ptr + 1;
  endtask

  int r0, b0, d0, g0, ok;
  logic [9:0] frame;

  initial begin
    // Reset
    @(negedge clk);
    chk("rst_txd", 32'(txd0), 32'd1);
    chk("rst_rd_en", 32'(rd_en0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(frame_done0), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_txd", 32'(txd0), 32'd1);
    chk("post_rst_busy", 32'(busy0), 32'd0);
    enable0 = 1'b1;
    r0 = rd_cnt; b0 = busy_cnt;
    repeat (100) @(negedge clk);
    chk("empty_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("empty_no_busy", 32'(busy_cnt - b0), 32'd0);
    enable0 = 1'b0;

    // Single byte 0xA5
    r0 = rd_cnt;
    wr(8'hA5);
    enable0 = 1'b1;
    @(negedge clk);
    chk("req_rd_en", 32'(rd_en0), 32'd1);
    chk("req_busy", 32'(busy0), 32'd1);
    chk("req_txd", 32'(txd0), 32'd1);
    @(negedge clk);
    chk("cap_rd_en", 32'(rd_en0), 32'd0);
    chk("cap_txd", 32'(txd0), 32'd1);
    @(negedge clk);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 4; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        chk($sformatf("a5_bit%0d_%0d", i, c), 32'(txd0), 32'(frame[i]));
      end
    end
    @(negedge clk);
    chk("a5_done", 32'(frame_done0), 32'd1);
    chk("a5_busy_end", 32'(busy0), 32'd0);
    @(negedge clk);
    chk("a5_done_pulse", 32'(frame_done0), 32'd0);
    chk("a5_len", 32'(flen), 32'd40);
    chk("a5_rd_once", 32'(rd_cnt - r0), 32'd1);
    chk("a5_decoded", 32'(decoded[decoded.size() - 1]), 32'hA5);
    enable0 = 1'b0;

    // Full drain of 16 bytes
    for (int i = 0; i < 16; i++) wr(8'(i));
    r0 = rd_cnt; d0 = decoded.size(); g0 = gaps.size();
    enable0 = 1'b1;
    ok = 0;
    for (int k = 0; k < 3000 && ok == 0; k++) begin
      @(negedge clk);
      if (decoded.size() == d0 + 16 && !busy0) ok = 1;
    end
    chk("drain_timeout", 32'(ok), 32'd1);
    chk("drain_rd_cnt", 32'(rd_cnt - r0), 32'd16);
    for (int i = 0; i < 16; i++)
      if (d0 + i < decoded.size())
        chk($sformatf("drain_byte%0d", i), 32'(decoded[d0 + i]), 32'(i));
    chk("drain_gap_count", 32'(gaps.size() - g0), 32'd16);
    for (int i = 1; i < 16; i++)
      if (g0 + i < gaps.size())
        chk($sformatf("drain_gap%0d", i), 32'(gaps[g0 + i]), 32'd3);
    chk("drain_empty", 32'(fifo_empty0), 32'd1);
    chk("drain_rd_while_empty", 32'(rd_empty_err), 32'd0);
    chk("drain_stop_err", 32'(stop_err), 32'd0);
    enable0 = 1'b0;

    // Parity: 0x07 -> odd parity 0, even parity 1; two stop bits
    @(negedge clk);
    p_dout = 8'h07; p_empty = 1'b0; p_en = 1'b1;
    @(negedge clk);
    chk("par_rd1", 32'(rd1), 32'd1);
    chk("par_rd2", 32'(rd2), 32'd1);
    p_empty = 1'b1; p_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("par_start1", 32'(txd1), 32'd0);
    chk("par_start2", 32'(txd2), 32'd0);
    repeat (5) @(negedge clk);
    chk("par_d0", 32'(txd1), 32'd1);
    repeat (32) @(negedge clk);
    chk("odd_parity", 32'(txd1), 32'd0);
    chk("even_parity", 32'(txd2), 32'd1);
    repeat (3) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("stop2_%0d", k), 32'({txd1, txd2, busy1}), 32'h7);
      @(negedge clk);
    end
    chk("par_done", 32'({fd1, fd2, busy1}), 32'h6);

    // Enable dropped mid-frame with 3 bytes queued
    wr(8'h11); wr(8'h22); wr(8'h33);
    r0 = rd_cnt; d0 = decoded.size();
    enable0 = 1'b1;
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      @(negedge clk);
      if (!txd0) ok = 1;
    end
    chk("en_start_timeout", 32'(ok), 32'd1);
    repeat (10) @(negedge clk);
    enable0 = 1'b0;
    ok = 0;
    for (int k = 0; k < 100 && ok == 0; k++) begin
      @(negedge clk);
      if (frame_done0) ok = 1;
    end
    chk("en_done_timeout", 32'(ok), 32'd1);
    repeat (30) @(negedge clk);
    chk("en_rd_cnt", 32'(rd_cnt - r0), 32'd1);
    chk("en_frames", 32'(decoded.size() - d0), 32'd1);
    chk("en_byte", 32'(decoded[decoded.size() - 1]), 32'h11);
    chk("en_remaining", 32'(wr_ptr - rd_ptr), 32'd2);

    // Reset in the middle of DATA
    enable0 = 1'b1;
    ok = 0;
    for (int k = 0; k < 20 && ok == 0; k++) begin
      @(negedge clk);
      if (!txd0) ok = 1;
    end
    chk("rstmid_start_timeout", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    chk("rstmid_bit0", 32'(txd0), 32'd0);
    #1 rstn = 1'b0;
    #1;
    chk("rstmid_txd", 32'(txd0), 32'd1);
    chk("rstmid_busy", 32'(busy0), 32'd0);
    chk("rstmid_rd_en", 32'(rd_en0), 32'd0);
    r0 = rd_cnt; d0 = decoded.size(); b0 = busy_cnt;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (100) @(negedge clk);
    chk("rstmid_no_rd", 32'(rd_cnt - r0), 32'd0);
    chk("rstmid_no_frame", 32'(decoded.size() - d0), 32'd0);
    chk("rstmid_no_busy", 32'(busy_cnt - b0), 32'd0);
    chk("rstmid_empty", 32'(fifo_empty0), 32'd1);
    chk("rstmid_idle_txd", 32'(txd0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
